// File: rtl/memory_access_pkg.sv
// Shared widths and state encoding for the memory access stage.
// Execute and writeback import the same default widths.
package memory_access_pkg;

  localparam int DEF_IALU_WORD_WIDTH = 16;
  localparam int DEF_REG_IDX_WIDTH   = 4;
  localparam int DEF_DMEM_ADDR_WIDTH = 12;
  localparam int DEF_DMEM_WORD_WIDTH = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } ma_state_t;

endpackage

// File: rtl/memory_access.sv
// Memory access stage: ALU pass-through or one load/store per
// instruction over req/ack, stalling upstream while it is outstanding.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = DEF_IALU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = DEF_REG_IDX_WIDTH,
  parameter int DMEM_ADDR_WIDTH = DEF_DMEM_ADDR_WIDTH,
  parameter int DMEM_WORD_WIDTH = DEF_DMEM_WORD_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_act_load,
  input  logic                       in_act_store,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [IALU_WORD_WIDTH-1:0] in_store_data,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       out_dmem_req,
  output logic                       out_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
  input  logic                       in_dmem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  ma_state_t                  r_state;
  ma_state_t                  w_state_nxt;
  logic                       r_req;
  logic                       w_req_nxt;
  logic                       r_we;
  logic                       w_we_nxt;
  logic [DMEM_ADDR_WIDTH-1:0] r_addr;
  logic [DMEM_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DMEM_WORD_WIDTH-1:0] r_wdata;
  logic [DMEM_WORD_WIDTH-1:0] w_wdata_nxt;
  logic [REG_IDX_WIDTH-1:0]   r_lat_idx;
  logic [REG_IDX_WIDTH-1:0]   w_lat_idx_nxt;
  logic                       r_lat_wr;
  logic                       w_lat_wr_nxt;
  logic                       r_act;
  logic                       w_act_nxt;
  logic [IALU_WORD_WIDTH-1:0] r_res;
  logic [IALU_WORD_WIDTH-1:0] w_res_nxt;
  logic [REG_IDX_WIDTH-1:0]   r_idx;
  logic [REG_IDX_WIDTH-1:0]   w_idx_nxt;
  logic                       w_mem_op;

  assign w_mem_op = in_act_load | in_act_store;

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_lat_idx_nxt = r_lat_idx;
    w_lat_wr_nxt  = r_lat_wr;
    w_act_nxt     = 1'b0;
    w_res_nxt     = '0;
    w_idx_nxt     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          // a load wins when both flags are set
          w_state_nxt   = WAIT_ACK;
          w_req_nxt     = 1'b1;
          w_we_nxt      = in_act_store & ~in_act_load;
          w_addr_nxt    = in_res[DMEM_ADDR_WIDTH-1:0];
          w_wdata_nxt   = in_store_data;
          w_lat_idx_nxt = in_res_reg_idx;
          w_lat_wr_nxt  = in_act_write_res_to_reg;
        end else begin
          w_act_nxt = in_act_write_res_to_reg;
          w_res_nxt = in_res;
          w_idx_nxt = in_res_reg_idx;
        end
      end
      WAIT_ACK: begin
        if (in_dmem_ack) begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
          if (!r_we) begin
            w_act_nxt = r_lat_wr;
            w_res_nxt = in_dmem_rdata;
            w_idx_nxt = r_lat_idx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_idx <= '0;
      r_lat_wr  <= 1'b0;
      r_act     <= 1'b0;
      r_res     <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_lat_idx <= w_lat_idx_nxt;
      r_lat_wr  <= w_lat_wr_nxt;
      r_act     <= w_act_nxt;
      r_res     <= w_res_nxt;
      r_idx     <= w_idx_nxt;
    end
  end

  assign out_stall                = (r_state == WAIT_ACK);
  assign out_dmem_req             = r_req;
  assign out_dmem_we              = r_we;
  assign out_dmem_addr            = r_addr;
  assign out_dmem_wdata           = r_wdata;
  assign out_act_write_res_to_reg = r_act;
  assign out_res                  = r_res;
  assign out_res_reg_idx          = r_idx;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model.
module tb_memory_access;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_act_write_res_to_reg = 1'b0;
  logic        in_act_load = 1'b0;
  logic        in_act_store = 1'b0;
  logic [15:0] in_res = '0;
  logic [15:0] in_store_data = '0;
  logic [3:0]  in_res_reg_idx = '0;
  logic        out_stall;
  logic        out_dmem_req;
  logic        out_dmem_we;
  logic [11:0] out_dmem_addr;
  logic [15:0] out_dmem_wdata;
  logic        in_dmem_ack = 1'b0;
  logic [15:0] in_dmem_rdata = '0;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;

  int n_cmp = 0;
  int n_err = 0;

  // last request fields the memory port should be showing
  logic        m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_wdata = '0;

  logic [51:0] exp_v;
  logic [51:0] obs;

  memory_access dut (
    .clock(clock),
    .reset(reset),
    .in_act_write_res_to_reg(in_act_write_res_to_reg),
    .in_act_load(in_act_load),
    .in_act_store(in_act_store),
    .in_res(in_res),
    .in_store_data(in_store_data),
    .in_res_reg_idx(in_res_reg_idx),
    .out_stall(out_stall),
    .out_dmem_req(out_dmem_req),
    .out_dmem_we(out_dmem_we),
    .out_dmem_addr(out_dmem_addr),
    .out_dmem_wdata(out_dmem_wdata),
    .in_dmem_ack(in_dmem_ack),
    .in_dmem_rdata(in_dmem_rdata),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_res(out_res),
    .out_res_reg_idx(out_res_reg_idx)
  );

  always #5 clock = ~clock;

  assign obs = {out_stall, out_dmem_req, out_dmem_we, out_dmem_addr,
                out_dmem_wdata, out_act_write_res_to_reg, out_res,
                out_res_reg_idx};

  function automatic logic [51:0] pk(
    input logic s, input logic r, input logic w,
    input logic [11:0] a, input logic [15:0] wd,
    input logic act, input logic [15:0] res, input logic [3:0] idx);
    return {s, r, w, a, wd, act, res, idx};
  endfunction

  task automatic drive(input logic ld, input logic st, input logic wr,
                       input logic [15:0] res, input logic [15:0] sd,
                       input logic [3:0] idx);
    in_act_load = ld;
    in_act_store = st;
    in_act_write_res_to_reg = wr;
    in_res = res;
    in_store_data = sd;
    in_res_reg_idx = idx;
  endtask

  task automatic junk();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
          16'($urandom), 4'($urandom));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (obs !== 52'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, 52'd0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    @(negedge clock);
    drive(0, 0, 1, 16'h1234, 16'h0, 4'd5);
    in_dmem_ack = 1'b1;
    in_dmem_rdata = 16'hDEAD;
    tick();
    exp_v = pk(0, 0, m_we, m_addr, m_wdata, 1, 16'h1234, 4'd5);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL pass_through: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
  endtask

  task automatic test_load_fast();
    @(negedge clock);
    drive(1, 0, 1, 16'hF0A0, 16'h0707, 4'd3);
    tick();
    m_we = 0; m_addr = 12'h0A0; m_wdata = 16'h0707;
    exp_v = pk(1, 1, 0, 12'h0A0, 16'h0707, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL load_req: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    junk();
    in_dmem_ack = 1'b1;
    in_dmem_rdata = 16'hBEEF;
    tick();
    exp_v = pk(0, 0, 0, 12'h0A0, 16'h0707, 1, 16'hBEEF, 4'd3);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL load_data: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
  endtask

  task automatic test_store_slow();
    @(negedge clock);
    drive(0, 1, 1, 16'h0010, 16'h5555, 4'd7);
    tick();
    m_we = 1; m_addr = 12'h010; m_wdata = 16'h5555;
    exp_v = pk(1, 1, 1, 12'h010, 16'h5555, 0, 16'h0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL store_wait%0d: got %h want %h", i, obs, exp_v);
      end
      @(negedge clock);
      junk();
      in_dmem_ack = (i == 2);
      tick();
    end
    exp_v = pk(0, 0, 1, 12'h010, 16'h5555, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL store_done: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
  endtask

  task automatic test_load_store_both();
    @(negedge clock);
    drive(1, 1, 1, 16'h3123, 16'hABCD, 4'd9);
    tick();
    m_we = 0; m_addr = 12'h123; m_wdata = 16'hABCD;
    exp_v = pk(1, 1, 0, 12'h123, 16'hABCD, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL both_req: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b1;
    in_dmem_rdata = 16'h7777;
    tick();
    exp_v = pk(0, 0, 0, 12'h123, 16'hABCD, 1, 16'h7777, 4'd9);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL both_done: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    drive(1, 0, 1, 16'h0456, 16'h0, 4'd2);
    tick();
    m_we = 0; m_addr = 12'h456; m_wdata = 16'h0;
    @(negedge clock);
    drive(0, 0, 1, 16'hCAFE, 16'h0, 4'd11);
    tick();
    exp_v = pk(1, 1, 0, 12'h456, 16'h0, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_held: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b1;
    in_dmem_rdata = 16'h9999;
    tick();
    exp_v = pk(0, 0, 0, 12'h456, 16'h0, 1, 16'h9999, 4'd2);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_load: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    tick();
    exp_v = pk(0, 0, 0, 12'h456, 16'h0, 1, 16'hCAFE, 4'd11);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_alu: got %h want %h", obs, exp_v);
    end
    @(negedge clock);
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
    tick();
    exp_v = pk(0, 0, 0, 12'h456, 16'h0, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_nodup: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock);
    drive(1, 0, 1, 16'h0FFF, 16'h1357, 4'd4);
    tick();
    exp_v = pk(1, 1, 0, 12'hFFF, 16'h1357, 0, 16'h0, 4'd0);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL rmid_req: got %h want %h", obs, exp_v);
    end
    #1;
    reset = 1'b1;
    #1;
    m_we = 0; m_addr = '0; m_wdata = '0;
    n_cmp++;
    if (obs !== 52'd0) begin
      n_err++;
      $display("FAIL rmid_async: got %h want %h", obs, 52'd0);
    end
    @(negedge clock);
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    in_dmem_ack = 1'b1;
    in_dmem_rdata = 16'h1111;
    tick();
    n_cmp++;
    if (obs !== 52'd0) begin
      n_err++;
      $display("FAIL rmid_late_ack: got %h want %h", obs, 52'd0);
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic        ld, st, wr;
    logic [15:0] res, sd, rd;
    logic [3:0]  idx;
    int          kind, lat;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      ld = (kind == 1) || (kind == 3);
      st = (kind == 2) || (kind == 3);
      wr = 1'($urandom);
      res = 16'($urandom);
      sd = 16'($urandom);
      idx = 4'($urandom);
      lat = $urandom_range(0, 3);
      @(negedge clock);
      drive(ld, st, wr, res, sd, idx);
      in_dmem_ack = 1'($urandom);
      in_dmem_rdata = 16'($urandom);
      tick();
      if (!(ld || st)) begin
        exp_v = pk(0, 0, m_we, m_addr, m_wdata, wr, res, idx);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL rand_alu#%0d: got %h want %h", n, obs, exp_v);
        end
      end else begin
        m_we = st && !ld;
        m_addr = res[11:0];
        m_wdata = sd;
        exp_v = pk(1, 1, m_we, m_addr, m_wdata, 0, 16'h0, 4'd0);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL rand_req#%0d: got %h want %h", n, obs, exp_v);
        end
        for (int k = 0; k < lat; k++) begin
          @(negedge clock);
          junk();
          in_dmem_ack = 1'b0;
          tick();
          n_cmp++;
          if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rand_wait#%0d: got %h want %h", n, obs, exp_v);
          end
        end
        rd = 16'($urandom);
        @(negedge clock);
        junk();
        in_dmem_ack = 1'b1;
        in_dmem_rdata = rd;
        tick();
        exp_v = pk(0, 0, m_we, m_addr, m_wdata, ld ? wr : 1'b0,
                   ld ? rd : 16'h0, ld ? idx : 4'd0);
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL rand_done#%0d: got %h want %h", n, obs, exp_v);
        end
      end
    end
    @(negedge clock);
    in_dmem_ack = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_fast();
    test_store_slow();
    test_load_store_both();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
